// File: rtl/archie_kbd_pkg.sv
// Shared types for the Archie keyboard link: inbound delivery FSM states
// and the status nibble the EXT_BUS handler reports alongside a poll.
package archie_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } rx_state_t;

    localparam logic [3:0] POLL_STATUS_NIBBLE = 4'hA;

endpackage

// File: rtl/kbd_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise o_ovf pulses.
module kbd_byte_fifo
    import archie_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot the push lands in.
    assign w_pop  = i_pop & ~w_empty;
    assign w_push = i_push & (~w_full | w_pop);

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = i_push & w_full & ~w_pop;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/kbd_link_sched.sv
// Keyboard byte scheduler between the core and the HPS: buffers outbound
// bytes for polling and paces inbound bytes to the core.
module kbd_link_sched
    import archie_kbd_pkg::*;
#(
    parameter int OUT_DEPTH = 8,
    parameter int IN_DEPTH  = 8,
    parameter int RX_GAP    = 64
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] core_tx_data,
    input  logic       core_tx_strobe,
    output logic [7:0] core_rx_data,
    output logic       core_rx_strobe,
    input  logic       core_rx_busy,
    input  logic       poll_req,
    output logic       poll_valid,
    output logic [7:0] poll_data,
    input  logic [7:0] push_data,
    input  logic       push_strobe,
    output logic       out_ovf,
    output logic       in_ovf,
    input  logic       ovf_clr
);

    localparam int GW = $clog2(RX_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(RX_GAP - 1);

    logic            r_tx_strobe_d;
    logic            r_out_ovf;
    logic            r_in_ovf;
    logic [7:0]      r_rx_data;
    logic [GW-1:0]   r_gap_cnt;
    rx_state_t       r_state;
    rx_state_t       w_state_nxt;

    logic            w_tx_rise;
    logic            w_rx_pop;
    logic [7:0]      w_out_head;
    logic            w_out_empty;
    logic            w_out_full;
    logic            w_out_ovf;
    logic [7:0]      w_in_head;
    logic            w_in_empty;
    logic            w_in_full;
    logic            w_in_ovf;

    // Edge detect starts at 0 so a strobe already high at reset release counts.
    assign w_tx_rise = core_tx_strobe & ~r_tx_strobe_d;

    kbd_byte_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (w_tx_rise),
        .i_data  (core_tx_data),
        .i_pop   (poll_req),
        .o_head  (w_out_head),
        .o_empty (w_out_empty),
        .o_full  (w_out_full),
        .o_ovf   (w_out_ovf)
    );

    kbd_byte_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (push_strobe),
        .i_data  (push_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_in_head),
        .o_empty (w_in_empty),
        .o_full  (w_in_full),
        .o_ovf   (w_in_ovf)
    );

    assign poll_valid     = ~w_out_empty;
    assign poll_data      = w_out_empty ? 8'h00 : w_out_head;
    assign core_rx_data   = r_rx_data;
    assign core_rx_strobe = (r_state == ST_ISSUE);
    assign out_ovf        = r_out_ovf;
    assign in_ovf         = r_in_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_rx_pop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_in_empty && !core_rx_busy) begin
                    w_rx_pop    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_rx_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_rx_pop) r_rx_data <= w_in_head;
            if (r_state == ST_ISSUE)
                r_gap_cnt <= GAP_LOAD;
            else if (r_state == ST_GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    // New overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tx_strobe_d <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_in_ovf      <= 1'b0;
        end else begin
            r_tx_strobe_d <= core_tx_strobe;
            if (w_out_ovf)    r_out_ovf <= 1'b1;
            else if (ovf_clr) r_out_ovf <= 1'b0;
            if (w_in_ovf)     r_in_ovf  <= 1'b1;
            else if (ovf_clr) r_in_ovf  <= 1'b0;
        end
    end

endmodule
